pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core. It owns the single shared instruction/data bus
//  and arbitrates between IF fetches and MEM load/stores, with MEM having priority.
//  It generates the stall[5:0] vector consumed by the PC, IF_ID, ID_EX, EX_MEM and MEM_WB
//  registers, and the flush to IF_ID on a taken branch.
//  A watchdog aborts bus accesses that never complete.
// PARAMETERS
//  ADDR_W   32  bus / PC address width
//  DATA_W   32  bus data width
//  TIMEOUT  15  max wait cycles per access before abort (>=1, counter width $clog2(TIMEOUT+1))
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  if_req        in   1       IF wants an instruction at if_addr
//  if_addr       in   ADDR_W  fetch address (current PC)
//  mem_req       in   1       MEM stage has a load/store
//  mem_we        in   1       1 = store
//  mem_addr      in   ADDR_W  load/store address
//  mem_wdata     in   DATA_W  store data
//  stallreq_id   in   1       ID hazard (load-use)
//  stallreq_ex   in   1       EX multi-cycle op in progress
//  branch_flag   in   1       taken branch resolved (ID or EX)
//  bus_req       out  1       bus request, held until bus_ready
//  bus_we        out  1       bus write enable
//  bus_addr      out  ADDR_W  bus address
//  bus_wdata     out  DATA_W  bus write data
//  bus_ready     in   1       access complete; bus_rdata valid this cycle
//  bus_rdata     in   DATA_W  bus read data
//  if_inst       out  DATA_W  fetched instruction (= bus_rdata)
//  if_valid      out  1       if_inst valid this cycle
//  mem_rdata     out  DATA_W  load data (= bus_rdata)
//  mem_done      out  1       MEM access finished this cycle
//  bus_err       out  1       1-cycle pulse: access aborted by watchdog
//  flush         out  1       clear IF_ID (= branch_flag)
//  stall         out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, kill=0, wdog=0, bus_we=0, bus_addr=0, bus_wdata=0.
//   Combinational outputs while in reset: bus_req=0, if_valid=0, mem_done=0, bus_err=0,
//   stall=6'b111111.
//  FSM states: IDLE, IF_ACC, MEM_ACC. bus_req = (state != IDLE).
//  IDLE:
//   - mem_req -> MEM_ACC; latch mem_addr/mem_we/mem_wdata into bus_*.
//   - else if_req && !branch_flag -> IF_ACC; latch if_addr, bus_we=0.
//   - A fetch is never granted in a branch_flag cycle, because the PC is stale then.
//  IF_ACC / MEM_ACC:
//   - bus_addr, bus_we and bus_wdata stay stable.
//   - wdog increments each cycle that bus_ready=0.
//   - On bus_ready: go to IDLE and clear wdog.
//   - IF_ACC: if_valid = bus_ready && !kill.
//   - MEM_ACC: mem_done = bus_ready.
//   - When wdog==TIMEOUT and !bus_ready: pulse bus_err for 1 cycle; mem_done=1 if MEM_ACC
//     (mem_rdata undefined); go to IDLE; clear wdog and kill.
//  Latency:
//   - A request seen in IDLE at cycle T gives bus_req high at T+1.
//   - Minimum completion is at T+1 (bus_ready same cycle).
//   - One IDLE re-arbitration cycle sits between consecutive accesses.
//  Kill:
//   - branch_flag in IF_ACC sets kill; kill clears on leaving IF_ACC.
//   - A killed fetch runs to bus_ready and is discarded (if_valid=0).
//   - branch_flag in the same cycle as bus_ready also discards that fetch.
//  flush = branch_flag (combinational). The IF_ID flush has priority over the stall hold.
//  stall (combinational, first match wins):
//   - MEM_ACC && !mem_done, or IDLE && mem_req: 6'b011111
//   - stallreq_ex: 6'b001111
//   - stallreq_id: 6'b000111
//   - if_req && !if_valid: 6'b000011
//   - otherwise: 6'b000000
//  Simultaneous events:
//   - mem_req arriving during IF_ACC waits until IF completes (no preemption).
//   - mem_req and if_req together in IDLE: MEM wins.
//  Reset mid-access: bus_req drops immediately. No completion or error is reported.
// TESTING
//  1. Fetch at 0x100, bus_ready 2 cycles after bus_req -> bus_addr=0x100; stall=000011
//     until the ready cycle; if_valid=1 with if_inst=bus_rdata; stall=0 on that cycle.
//  2. if_req and mem_req(store 0xDEADBEEF @0x2000) in the same cycle -> MEM granted first,
//     bus_we=1, stall=011111 until mem_done; fetch granted afterwards.
//  3. branch_flag during IF_ACC, then bus_ready -> flush=1 that cycle; if_valid stays 0;
//     the next fetch uses the new if_addr.
//  4. bus_ready never asserted in MEM_ACC -> after 15 wait cycles bus_err=1 and mem_done=1
//     for 1 cycle; state returns to IDLE; stall releases.
//  5. stallreq_id=1 with IF idle, then stallreq_ex=1 -> stall 000111, then 001111.
//  6. rst_n low mid-MEM_ACC -> bus_req=0 and stall=111111 immediately; after release,
//     first grant occurs from IDLE.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: arbitrates the shared instruction/data bus between IF and MEM
// (MEM first), drives the stage stall vector and IF_ID flush, and aborts hung accesses.
module pipeline_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              branch_flag,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              bus_err,
  output logic              flush,
  output logic [5:0]        stall
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      wdog_q      <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      wdog_q      <= wdog_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    wdog_d      = wdog_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_valid    = 1'b0;
    mem_done    = 1'b0;
    bus_err     = 1'b0;
    timeout     = (state_q != IDLE) && !bus_ready && (wdog_q == WD_MAX);

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        kill_d = 1'b0;
        // MEM wins; a fetch is refused while branch_flag says the PC is stale.
        if (mem_req) begin
          state_d     = MEM_ACC;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (if_req && !branch_flag) begin
          state_d    = IF_ACC;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
        end
      end
      IF_ACC: begin
        if (bus_ready) begin
          state_d  = IDLE;
          wdog_d   = '0;
          kill_d   = 1'b0;
          if_valid = !kill_q && !branch_flag;
        end else if (timeout) begin
          state_d = IDLE;
          wdog_d  = '0;
          kill_d  = 1'b0;
          bus_err = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          if (branch_flag) kill_d = 1'b1;
        end
      end
      MEM_ACC: begin
        if (bus_ready) begin
          state_d  = IDLE;
          wdog_d   = '0;
          mem_done = 1'b1;
        end else if (timeout) begin
          state_d  = IDLE;
          wdog_d   = '0;
          kill_d   = 1'b0;
          mem_done = 1'b1;
          bus_err  = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
        kill_d  = 1'b0;
      end
    endcase

    // Stall priority: bus busy for MEM, EX multi-cycle, ID hazard, fetch outstanding.
    if (!rst_n)
      stall = 6'b111111;
    else if (((state_q == MEM_ACC) && !mem_done) || ((state_q == IDLE) && mem_req))
      stall = 6'b011111;
    else if (stallreq_ex)
      stall = 6'b001111;
    else if (stallreq_id)
      stall = 6'b000111;
    else if (if_req && !if_valid)
      stall = 6'b000011;
    else
      stall = 6'b000000;
  end

  assign bus_req   = (state_q != IDLE);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_inst   = bus_rdata;
  assign mem_rdata = bus_rdata;
  assign flush     = branch_flag;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle vector table plus directed timeout and reset sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        branch_flag = 1'b0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] if_inst, mem_rdata;
  logic        if_valid, mem_done, bus_err, flush;
  logic [5:0]  stall;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .branch_flag(branch_flag),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .if_inst(if_inst), .if_valid(if_valid), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus_err(bus_err), .flush(flush), .stall(stall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic        sid;
    logic        sex;
    logic        br;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [5:0]  e_stall;
    logic        e_iv;
    logic        e_md;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic mr,
                             input logic mw, input logic [31:0] ma, input logic [31:0] md,
                             input logic sid, input logic sex, input logic br,
                             input logic rdy, input logic [31:0] rd, input logic e_req,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [5:0] e_stall, input logic e_iv,
                             input logic e_md, input logic e_err);
    vec_t r;
    r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ma = ma; r.md = md;
    r.sid = sid; r.sex = sex; r.br = br; r.rdy = rdy; r.rd = rd;
    r.e_req = e_req; r.e_we = e_we; r.e_addr = e_addr; r.e_stall = e_stall;
    r.e_iv = e_iv; r.e_md = e_md; r.e_err = e_err;
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
    mem_wdata = '0; stallreq_id = 1'b0; stallreq_ex = 1'b0; branch_flag = 1'b0;
    bus_ready = 1'b0; bus_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i, input vec_t t);
    string p;
    if_req = t.ir; if_addr = t.ia; mem_req = t.mr; mem_we = t.mw; mem_addr = t.ma;
    mem_wdata = t.md; stallreq_id = t.sid; stallreq_ex = t.sex; branch_flag = t.br;
    bus_ready = t.rdy; bus_rdata = t.rd;
    @(negedge clk);
    p = $sformatf("row%0d", i);
    chk({p, "_bus_req"}, 32'(bus_req), 32'(t.e_req));
    chk({p, "_stall"}, 32'(stall), 32'(t.e_stall));
    chk({p, "_if_valid"}, 32'(if_valid), 32'(t.e_iv));
    chk({p, "_mem_done"}, 32'(mem_done), 32'(t.e_md));
    chk({p, "_bus_err"}, 32'(bus_err), 32'(t.e_err));
    chk({p, "_flush"}, 32'(flush), 32'(t.br));
    if (t.e_req) begin
      chk({p, "_bus_addr"}, bus_addr, t.e_addr);
      chk({p, "_bus_we"}, 32'(bus_we), 32'(t.e_we));
      if (t.e_we) chk({p, "_bus_wdata"}, bus_wdata, t.md);
    end
    if (t.e_iv) chk({p, "_if_inst"}, if_inst, t.rd);
    if (t.e_md && !t.e_err) chk({p, "_mem_rdata"}, mem_rdata, t.rd);
    next_cycle();
  endtask

  // ---------------- main test ----------------
  initial begin
    int err_at;

    // reset: registered bus fields cleared, combinational outputs forced
    drive_idle();
    #1 rst_n = 1'b0;
    mem_req = 1'b1; if_req = 1'b1;
    #2;
    chk("rst_stall", 32'(stall), 32'h3f);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive_idle();
    rst_n = 1'b1;

    //            ir ia        mr mw ma         md            sid sex br rdy rd          req we addr      stall       iv md err
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000000, 0, 0, 0));
    // fetch 0x100, ready two cycles after bus_req
    vecs.push_back(v(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      1, 0, 32'h100,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      1, 0, 32'h100,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h13,     1, 0, 32'h100,  6'b000000, 1, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000000, 0, 0, 0));
    // IF and MEM store together: MEM first, then fetch
    vecs.push_back(v(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b011111, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,      1, 1, 32'h2000, 6'b011111, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 0, 0, 1, 32'h11,     1, 1, 32'h2000, 6'b000011, 0, 1, 0));
    vecs.push_back(v(1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h200,    1, 0, 32'h104,  6'b000000, 1, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000000, 0, 0, 0));
    // branch during IF_ACC kills the fetch; refetch from new target
    vecs.push_back(v(1, 32'h108, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h108, 0, 0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0,      1, 0, 32'h108,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h300, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'hBAD,    1, 0, 32'h108,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h300, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h300, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h55,     1, 0, 32'h300,  6'b000000, 1, 0, 0));
    // branch on the ready cycle discards; no fetch granted while branch_flag
    vecs.push_back(v(1, 32'h304, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h304, 0, 0, 32'h0,    32'h0,        0, 0, 1, 1, 32'hBAD,    1, 0, 32'h304,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h304, 0, 0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h400, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h400, 0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h77,     1, 0, 32'h400,  6'b000000, 1, 0, 0));
    // ID / EX stall requests
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000111, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 1, 0, 0, 32'h0,      0, 0, 32'h0,    6'b001111, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 1, 0, 0, 32'h0,      0, 0, 32'h0,    6'b001111, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000000, 0, 0, 0));
    // load outranks EX stall
    vecs.push_back(v(0, 32'h0,   1, 0, 32'h3000, 32'h0,        0, 1, 0, 0, 32'h0,      0, 0, 32'h0,    6'b011111, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,   1, 0, 32'h3000, 32'h0,        0, 1, 0, 0, 32'h0,      1, 0, 32'h3000, 6'b011111, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 1, 0, 1, 32'hAB,     1, 0, 32'h3000, 6'b001111, 0, 1, 0));
    // mem_req during IF_ACC waits for the fetch
    vecs.push_back(v(1, 32'h500, 0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h500, 1, 0, 32'h3004, 32'h0,        0, 0, 0, 0, 32'h0,      1, 0, 32'h500,  6'b000011, 0, 0, 0));
    vecs.push_back(v(1, 32'h500, 1, 0, 32'h3004, 32'h0,        0, 0, 0, 1, 32'h99,     1, 0, 32'h500,  6'b000000, 1, 0, 0));
    vecs.push_back(v(1, 32'h500, 1, 0, 32'h3004, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b011111, 0, 0, 0));
    vecs.push_back(v(1, 32'h500, 1, 0, 32'h3004, 32'h0,        0, 0, 0, 1, 32'h42,     1, 0, 32'h3004, 6'b000011, 0, 1, 0));
    vecs.push_back(v(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    6'b000000, 0, 0, 0));

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // watchdog: MEM store that never completes
    drive_idle();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'h1234;
    @(negedge clk);
    chk("wd_grant_stall", 32'(stall), 32'h1f);
    next_cycle();
    mem_req = 1'b0;
    err_at = -1;
    for (int k = 0; k < 40 && err_at < 0; k++) begin
      @(negedge clk);
      if (bus_err) begin
        err_at = k;
        chk("wd_mem_done", 32'(mem_done), 32'h1);
        chk("wd_release_stall", 32'(stall), 32'h0);
      end else begin
        chk($sformatf("wd_wait%0d_stall", k), 32'(stall), 32'h1f);
        chk($sformatf("wd_wait%0d_addr", k), bus_addr, 32'h4000);
        chk($sformatf("wd_wait%0d_done", k), 32'(mem_done), 32'h0);
      end
      next_cycle();
    end
    chk("wd_err_cycle", err_at, 32'd15);
    @(negedge clk);
    chk("wd_after_bus_req", 32'(bus_req), 32'h0);
    chk("wd_after_bus_err", 32'(bus_err), 32'h0);
    chk("wd_after_stall", 32'(stall), 32'h0);
    next_cycle();

    // reset in the middle of a MEM access
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h5000; mem_wdata = 32'hCAFE;
    next_cycle();
    mem_req = 1'b0;
    @(negedge clk);
    chk("mid_bus_req", 32'(bus_req), 32'h1);
    #1;
    rst_n = 1'b0;
    bus_ready = 1'b1;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h3f);
    chk("mid_rst_mem_done", 32'(mem_done), 32'h0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'h0);
    chk("mid_rst_bus_addr", bus_addr, 32'h0);
    next_cycle();
    #2;
    drive_idle();
    rst_n = 1'b1;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    chk("post_rst_idle_req", 32'(bus_req), 32'h0);
    chk("post_rst_idle_stall", 32'(stall), 32'h3);
    next_cycle();
    @(negedge clk);
    chk("post_rst_grant_req", 32'(bus_req), 32'h1);
    chk("post_rst_grant_addr", bus_addr, 32'h600);
    next_cycle();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
